// File: rtl/arp_recv.sv
// rtl/arp_recv.sv - Ethernet ARP frame receiver with MAC/IP filtering
//
// Purpose: parses a raw byte stream (preamble, SFD, Ethernet header, ARP
// payload, padding, FCS), keeps only ARP request/reply frames addressed to
// this station (unicast MAC or broadcast, TPA = own IP) and presents the
// parsed fields on a held output register until acknowledged.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_rx_data, i_rx_dv  received byte stream, one byte per clock while dv=1
//   i_local_mac/ip      own addresses used by the filters
//   o_valid, i_ack      output-hold handshake
//   o_operation         ARP OPER low bits (1 request, 2 reply)
//   o_src_mac           Ethernet source MAC
//   o_SHA/o_SPA         sender hardware / protocol address
//   o_THA/o_TPA         target hardware / protocol address
//   o_drop_cnt          saturating count of filtered or truncated frames
//   o_ovf_cnt           saturating count of good frames lost to a held output
module arp_recv (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_dv,
   input  logic [47:0] i_local_mac,
   input  logic [31:0] i_local_ip,
   output logic        o_valid,
   input  logic        i_ack,
   output logic [1:0]  o_operation,
   output logic [47:0] o_src_mac,
   output logic [47:0] o_SHA,
   output logic [47:0] o_THA,
   output logic [31:0] o_SPA,
   output logic [31:0] o_TPA,
   output logic [7:0]  o_drop_cnt,
   output logic [7:0]  o_ovf_cnt
);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_PREAMBLE   = 4'd1;
   localparam logic [3:0] S_DST_MAC    = 4'd2;
   localparam logic [3:0] S_SRC_MAC    = 4'd3;
   localparam logic [3:0] S_ETHER_TYPE = 4'd4;
   localparam logic [3:0] S_ARP_HEADER = 4'd5;
   localparam logic [3:0] S_SHA        = 4'd6;
   localparam logic [3:0] S_SPA        = 4'd7;
   localparam logic [3:0] S_THA        = 4'd8;
   localparam logic [3:0] S_TPA        = 4'd9;
   localparam logic [3:0] S_WAIT_END   = 4'd10;
   localparam logic [3:0] S_DROP       = 4'd11;

   localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;
   localparam logic [15:0] ETYPE_ARP  = 16'h0806;
   localparam logic [63:0] HDR_REQ    = 64'h0001_0800_0604_0001;
   localparam logic [63:0] HDR_REPLY  = 64'h0001_0800_0604_0002;

   // Parser state
   logic [3:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;

   // Field shift registers; only the bits needed later are kept. The
   // filter compare always uses {shift_q, current byte} on the last byte.
   logic [39:0] dst_q, dst_d;
   logic [47:0] src_q, src_d;
   logic [7:0]  etype_q, etype_d;
   logic [55:0] hdr_q, hdr_d;
   logic [47:0] sha_q, sha_d;
   logic [31:0] spa_q, spa_d;
   logic [47:0] tha_q, tha_d;
   logic [31:0] tpa_q, tpa_d;

   // Output holding registers
   logic        valid_q, valid_d;
   logic [1:0]  op_q, op_d;
   logic [47:0] out_src_q, out_src_d;
   logic [47:0] out_sha_q, out_sha_d;
   logic [31:0] out_spa_q, out_spa_d;
   logic [47:0] out_tha_q, out_tha_d;
   logic [31:0] out_tpa_q, out_tpa_d;
   logic [7:0]  drop_cnt_q, drop_cnt_d;
   logic [7:0]  ovf_cnt_q, ovf_cnt_d;

   logic        drop_evt;
   logic        done_evt;
   logic        load;
   logic [47:0] dst_full;
   logic [15:0] etype_full;
   logic [63:0] hdr_full;
   logic [31:0] tpa_full;

   assign dst_full   = {dst_q, i_rx_data};
   assign etype_full = {etype_q, i_rx_data};
   assign hdr_full   = {hdr_q, i_rx_data};
   assign tpa_full   = {tpa_q[23:0], i_rx_data};

   // Frame parser
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dst_d    = dst_q;
      src_d    = src_q;
      etype_d  = etype_q;
      hdr_d    = hdr_q;
      sha_d    = sha_q;
      spa_d    = spa_q;
      tha_d    = tha_q;
      tpa_d    = tpa_q;
      drop_evt = 1'b0;
      done_evt = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_rx_dv) begin
               state_d = (i_rx_data == 8'h55) ? S_PREAMBLE : S_DROP;
            end
         end
         S_PREAMBLE: begin
            // cnt_q counts 0x55 bytes beyond the one seen in IDLE, so a
            // further 0x55 at cnt_q == 6 would be the eighth.
            if (!i_rx_dv) begin
               state_d  = S_IDLE;
               drop_evt = 1'b1;
            end else if (i_rx_data == 8'hD5) begin
               state_d = S_DST_MAC;
            end else if (i_rx_data == 8'h55 && cnt_q < 5'd6) begin
               cnt_d = cnt_q + 5'd1;
            end else begin
               state_d = S_DROP;
            end
         end
         S_DST_MAC: begin
            if (!i_rx_dv) begin
               state_d  = S_IDLE;
               drop_evt = 1'b1;
            end else begin
               dst_d = dst_full[39:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd5) begin
                  state_d = (dst_full == i_local_mac || dst_full == BCAST_MAC)
                            ? S_SRC_MAC : S_DROP;
               end
            end
         end
         S_SRC_MAC: begin
            if (!i_rx_dv) begin
               state_d  = S_IDLE;
               drop_evt = 1'b1;
            end else begin
               src_d = {src_q[39:0], i_rx_data};
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd5) state_d = S_ETHER_TYPE;
            end
         end
         S_ETHER_TYPE: begin
            if (!i_rx_dv) begin
               state_d  = S_IDLE;
               drop_evt = 1'b1;
            end else begin
               etype_d = i_rx_data;
               cnt_d   = cnt_q + 5'd1;
               if (cnt_q == 5'd1) begin
                  state_d = (etype_full == ETYPE_ARP) ? S_ARP_HEADER : S_DROP;
               end
            end
         end
         S_ARP_HEADER: begin
            if (!i_rx_dv) begin
               state_d  = S_IDLE;
               drop_evt = 1'b1;
            end else begin
               hdr_d = hdr_full[55:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  state_d = (hdr_full == HDR_REQ || hdr_full == HDR_REPLY)
                            ? S_SHA : S_DROP;
               end
            end
         end
         S_SHA: begin
            if (!i_rx_dv) begin
               state_d  = S_IDLE;
               drop_evt = 1'b1;
            end else begin
               sha_d = {sha_q[39:0], i_rx_data};
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd5) state_d = S_SPA;
            end
         end
         S_SPA: begin
            if (!i_rx_dv) begin
               state_d  = S_IDLE;
               drop_evt = 1'b1;
            end else begin
               spa_d = {spa_q[23:0], i_rx_data};
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd3) state_d = S_THA;
            end
         end
         S_THA: begin
            if (!i_rx_dv) begin
               state_d  = S_IDLE;
               drop_evt = 1'b1;
            end else begin
               tha_d = {tha_q[39:0], i_rx_data};
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd5) state_d = S_TPA;
            end
         end
         S_TPA: begin
            if (!i_rx_dv) begin
               state_d  = S_IDLE;
               drop_evt = 1'b1;
            end else begin
               tpa_d = tpa_full;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd3) begin
                  state_d = (tpa_full == i_local_ip) ? S_WAIT_END : S_DROP;
               end
            end
         end
         S_WAIT_END: begin
            // Padding and FCS pass through unchecked.
            if (!i_rx_dv) begin
               state_d  = S_IDLE;
               done_evt = 1'b1;
            end
         end
         S_DROP: begin
            if (!i_rx_dv) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == S_DROP && state_q != S_DROP) drop_evt = 1'b1;
      if (state_d != state_q) cnt_d = 5'd0;
   end

   // Output hold and statistics
   always_comb begin
      // A completed frame may replace the held one only when the held one is
      // free or being acknowledged in this very cycle.
      load       = done_evt && (!valid_q || i_ack);
      valid_d    = valid_q && !i_ack;
      op_d       = op_q;
      out_src_d  = out_src_q;
      out_sha_d  = out_sha_q;
      out_spa_d  = out_spa_q;
      out_tha_d  = out_tha_q;
      out_tpa_d  = out_tpa_q;
      drop_cnt_d = drop_cnt_q;
      ovf_cnt_d  = ovf_cnt_q;

      if (load) begin
         valid_d   = 1'b1;
         op_d      = hdr_q[1:0];
         out_src_d = src_q;
         out_sha_d = sha_q;
         out_spa_d = spa_q;
         out_tha_d = tha_q;
         out_tpa_d = tpa_q;
      end
      if (done_evt && !load && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
      if (drop_evt && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 5'd0;
         dst_q      <= '0;
         src_q      <= '0;
         etype_q    <= '0;
         hdr_q      <= '0;
         sha_q      <= '0;
         spa_q      <= '0;
         tha_q      <= '0;
         tpa_q      <= '0;
         valid_q    <= 1'b0;
         op_q       <= '0;
         out_src_q  <= '0;
         out_sha_q  <= '0;
         out_spa_q  <= '0;
         out_tha_q  <= '0;
         out_tpa_q  <= '0;
         drop_cnt_q <= '0;
         ovf_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dst_q      <= dst_d;
         src_q      <= src_d;
         etype_q    <= etype_d;
         hdr_q      <= hdr_d;
         sha_q      <= sha_d;
         spa_q      <= spa_d;
         tha_q      <= tha_d;
         tpa_q      <= tpa_d;
         valid_q    <= valid_d;
         op_q       <= op_d;
         out_src_q  <= out_src_d;
         out_sha_q  <= out_sha_d;
         out_spa_q  <= out_spa_d;
         out_tha_q  <= out_tha_d;
         out_tpa_q  <= out_tpa_d;
         drop_cnt_q <= drop_cnt_d;
         ovf_cnt_q  <= ovf_cnt_d;
      end
   end

   assign o_valid     = valid_q;
   assign o_operation = op_q;
   assign o_src_mac   = out_src_q;
   assign o_SHA       = out_sha_q;
   assign o_SPA       = out_spa_q;
   assign o_THA       = out_tha_q;
   assign o_TPA       = out_tpa_q;
   assign o_drop_cnt  = drop_cnt_q;
   assign o_ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_arp_recv.sv
// tb/tb_arp_recv.sv - directed self-checking bench for arp_recv
module tb_arp_recv;

   localparam logic [47:0] LMAC  = 48'h02AA_BBCC_DDEE;
   localparam logic [31:0] LIP   = 32'hC0A8_0102;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] SRCM  = 48'h0A0B_0C0D_0E0F;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_dv = 1'b0;
   logic        i_ack = 1'b0;
   logic        o_valid;
   logic [1:0]  o_operation;
   logic [47:0] o_src_mac, o_SHA, o_THA;
   logic [31:0] o_SPA, o_TPA;
   logic [7:0]  o_drop_cnt, o_ovf_cnt;

   int checks = 0;
   int failures = 0;
   logic [7:0] fr[$];

   arp_recv dut (
      .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .i_rx_dv(i_rx_dv),
      .i_local_mac(LMAC), .i_local_ip(LIP), .o_valid(o_valid), .i_ack(i_ack),
      .o_operation(o_operation), .o_src_mac(o_src_mac), .o_SHA(o_SHA),
      .o_THA(o_THA), .o_SPA(o_SPA), .o_TPA(o_TPA),
      .o_drop_cnt(o_drop_cnt), .o_ovf_cnt(o_ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_n(input logic [63:0] v, input int nbytes);
      for (int i = nbytes - 1; i >= 0; i--) fr.push_back(v[i*8 +: 8]);
   endtask

   // Frame layout for npre=7: preamble 0..6, SFD 7, dst 8..13, src 14..19,
   // type 20..21, ARP header 22..29, SHA 30..35, SPA 36..39, THA 40..45,
   // TPA 46..49, padding 50..67, FCS 68..71.
   task automatic build(input int npre, input logic [47:0] dst, input logic [15:0] et,
                        input logic [15:0] oper, input logic [47:0] sha,
                        input logic [31:0] spa, input logic [47:0] tha,
                        input logic [31:0] tpa);
      fr.delete();
      for (int i = 0; i < npre; i++) fr.push_back(8'h55);
      fr.push_back(8'hD5);
      push_n({16'h0, dst}, 6);
      push_n({16'h0, SRCM}, 6);
      push_n({48'h0, et}, 2);
      push_n(64'h0000_0001_0800_0604, 6);
      push_n({48'h0, oper}, 2);
      push_n({16'h0, sha}, 6);
      push_n({32'h0, spa}, 4);
      push_n({16'h0, tha}, 6);
      push_n({32'h0, tpa}, 4);
      for (int i = 0; i < 18; i++) fr.push_back(8'h00);
      push_n(64'hDEAD_BEEF, 4);
   endtask

   task automatic send_range(input int first, input int last, input bit end_low);
      for (int i = first; i <= last; i++) begin
         i_rx_data = fr[i];
         i_rx_dv   = 1'b1;
         tick();
      end
      if (end_low) begin
         i_rx_data = 8'h00;
         i_rx_dv   = 1'b0;
         tick();
      end
   endtask

   task automatic send_all();
      send_range(0, fr.size() - 1, 1'b1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic do_ack();
      i_ack = 1'b1;
      tick();
      i_ack = 1'b0;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", o_valid, 0);
      chk("rst_drop", o_drop_cnt, 0);
      chk("rst_ovf", o_ovf_cnt, 0);
      chk("rst_sha", o_SHA, 0);
      chk("rst_op", o_operation, 0);

      // Broadcast request for our IP
      build(7, BCAST, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0101,
            48'h0, LIP);
      send_range(0, fr.size() - 1, 1'b0);
      chk("req_valid_before_dv_fall", o_valid, 0);
      i_rx_dv = 1'b0;
      tick();
      chk("req_valid", o_valid, 1);
      chk("req_op", o_operation, 1);
      chk("req_sha", o_SHA, 48'h0011_2233_4455);
      chk("req_spa", o_SPA, 32'hC0A8_0101);
      chk("req_tha", o_THA, 0);
      chk("req_tpa", o_TPA, LIP);
      chk("req_src", o_src_mac, SRCM);
      chk("req_drop", o_drop_cnt, 0);
      chk("req_ovf", o_ovf_cnt, 0);
      do_ack();
      chk("ack_clears_valid", o_valid, 0);
      chk("ack_fields_kept", o_SHA, 48'h0011_2233_4455);

      // Wrong target IP
      build(7, BCAST, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0101,
            48'h0, 32'hC0A8_0103);
      send_all();
      chk("tpa_miss_valid", o_valid, 0);
      chk("tpa_miss_drop", o_drop_cnt, 1);

      // Unicast reply, shortest preamble
      build(1, LMAC, 16'h0806, 16'h0002, 48'h6655_4433_2211, 32'h0A00_0001,
            LMAC, LIP);
      send_all();
      chk("reply_valid", o_valid, 1);
      chk("reply_op", o_operation, 2);
      chk("reply_sha", o_SHA, 48'h6655_4433_2211);
      chk("reply_tha", o_THA, LMAC);
      chk("reply_drop", o_drop_cnt, 1);
      do_ack();

      // Eight preamble bytes
      build(8, BCAST, 16'h0806, 16'h0001, 48'h1, 32'h1, 48'h0, LIP);
      send_all();
      chk("pre8_valid", o_valid, 0);
      chk("pre8_drop", o_drop_cnt, 2);

      // Bad OPER
      build(7, BCAST, 16'h0806, 16'h0003, 48'h1, 32'h1, 48'h0, LIP);
      send_all();
      chk("oper3_drop", o_drop_cnt, 3);

      // Foreign unicast MAC
      build(7, 48'h02AA_BBCC_DDEF, 16'h0806, 16'h0001, 48'h1, 32'h1, 48'h0, LIP);
      send_all();
      chk("dst_miss_valid", o_valid, 0);
      chk("dst_miss_drop", o_drop_cnt, 4);

      // IPv4 ethertype, then truncation after SPA
      do_reset();
      chk("rst2_drop", o_drop_cnt, 0);
      build(7, BCAST, 16'h0800, 16'h0001, 48'h1, 32'h1, 48'h0, LIP);
      send_all();
      chk("etype_drop", o_drop_cnt, 1);
      build(7, BCAST, 16'h0806, 16'h0001, 48'h1, 32'h1, 48'h0, LIP);
      send_range(0, 39, 1'b1);
      chk("trunc_drop", o_drop_cnt, 2);
      chk("trunc_valid", o_valid, 0);

      // Held output: A loaded, B lost, C accepted with ack on load cycle
      do_reset();
      build(7, BCAST, 16'h0806, 16'h0001, 48'h1111_1111_1111, 32'h1, 48'h0, LIP);
      send_all();
      chk("hold_a_valid", o_valid, 1);
      build(7, BCAST, 16'h0806, 16'h0001, 48'h2222_2222_2222, 32'h2, 48'h0, LIP);
      send_all();
      chk("hold_b_valid", o_valid, 1);
      chk("hold_b_sha", o_SHA, 48'h1111_1111_1111);
      chk("hold_b_ovf", o_ovf_cnt, 1);
      build(7, BCAST, 16'h0806, 16'h0001, 48'h3333_3333_3333, 32'h3, 48'h0, LIP);
      send_range(0, fr.size() - 1, 1'b0);
      i_rx_dv = 1'b0;
      i_ack   = 1'b1;
      tick();
      i_ack   = 1'b0;
      chk("hold_c_valid", o_valid, 1);
      chk("hold_c_sha", o_SHA, 48'h3333_3333_3333);
      chk("hold_c_ovf", o_ovf_cnt, 1);
      tick();
      chk("hold_c_valid_kept", o_valid, 1);
      do_ack();
      chk("hold_c_cleared", o_valid, 0);

      // Drop counter saturation
      do_reset();
      for (int n = 0; n < 300; n++) begin
         i_rx_data = 8'h00;
         i_rx_dv   = 1'b1;
         tick();
         i_rx_dv   = 1'b0;
         tick();
      end
      chk("sat_drop", o_drop_cnt, 8'hFF);
      chk("sat_ovf", o_ovf_cnt, 0);

      // Reset in the middle of SHA
      do_reset();
      build(7, BCAST, 16'h0806, 16'h0001, 48'hAAAA_AAAA_AAAA, 32'h1, 48'h0, LIP);
      send_all();
      chk("midrst_pre_valid", o_valid, 1);
      build(7, BCAST, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'h1, 48'h0, LIP);
      send_range(0, 32, 1'b0);
      rst       = 1'b1;
      i_rx_data = fr[33];
      i_rx_dv   = 1'b1;
      tick();
      rst       = 1'b0;
      chk("midrst_valid", o_valid, 0);
      chk("midrst_drop", o_drop_cnt, 0);
      chk("midrst_ovf", o_ovf_cnt, 0);
      chk("midrst_sha", o_SHA, 0);
      send_range(34, fr.size() - 1, 1'b1);
      chk("midrst_tail_drop", o_drop_cnt, 1);
      chk("midrst_tail_valid", o_valid, 0);
      send_all();
      chk("midrst_next_valid", o_valid, 1);
      chk("midrst_next_sha", o_SHA, 48'h0011_2233_4455);
      chk("midrst_next_drop", o_drop_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arp_recv.md
ARP_RECV -- requirements
Module: arp_recv

Interface
REQ-001 clk  in  1  sole clock; all logic on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 i_rx_data  in  8  received byte, valid when i_rx_dv=1; preamble and SFD included, FCS trailing.
REQ-004 i_rx_dv  in  1  frame-active strobe, one byte per clk, contiguous per frame.
REQ-005 i_local_mac  in  48  own MAC; sampled continuously.
REQ-006 i_local_ip  in  32  own IPv4 address; sampled continuously.
REQ-007 o_valid  out  1  parsed ARP frame available on output fields.
REQ-008 i_ack  in  1  consumer accepts frame; effective only while o_valid=1.
REQ-009 o_operation  out  2  ARP OPER low bits (1=request, 2=reply).
REQ-010 o_src_mac  out  48  Ethernet source MAC.
REQ-011 o_SHA / o_THA  out  48 each  sender / target hardware address.
REQ-012 o_SPA / o_TPA  out  32 each  sender / target protocol address.
REQ-013 o_drop_cnt  out  8  saturating count of frames rejected by filter or truncation.
REQ-014 o_ovf_cnt  out  8  saturating count of accepted frames lost because o_valid was held.

Function
REQ-015 States: IDLE, PREAMBLE, DST_MAC, SRC_MAC, ETHER_TYPE, ARP_HEADER, SHA, SPA, THA, TPA, WAIT_END, DROP; 5-bit byte counter reset on every state entry.
REQ-016 IDLE: byte 0x55 with i_rx_dv=1 -> PREAMBLE; any other byte with dv=1 -> DROP.
REQ-017 PREAMBLE: 0x55 stays (max 7 total 0x55 bytes); 0xD5 after 1..7 0x55 -> DST_MAC; any other byte or 8th 0x55 -> DROP.
REQ-018 Byte counts per state: DST_MAC 6, SRC_MAC 6, ETHER_TYPE 2, ARP_HEADER 8, SHA 6, SPA 4, THA 6, TPA 4; fields shifted in MSB first; advance on last byte.
REQ-019 DST_MAC filter: equals i_local_mac or 48'hFFFFFFFFFFFF, else DROP.
REQ-020 ETHER_TYPE must be 16'h0806, else DROP.
REQ-021 ARP_HEADER must equal 0001_0800_06_04 followed by OPER 0x0001 or 0x0002, else DROP.
REQ-022 TPA must equal i_local_ip, else DROP; on pass -> WAIT_END.
REQ-023 Filter decision taken on the last byte of its field; DROP entered the next cycle.
REQ-024 WAIT_END: consume padding and FCS bytes unchecked (FCS not verified); exit on first cycle with i_rx_dv=0.
REQ-025 i_rx_dv=0 in any state between PREAMBLE and TPA inclusive: truncation -> IDLE, o_drop_cnt +1.
REQ-026 DROP: o_drop_cnt +1 on entry; remain until i_rx_dv=0, then IDLE.
REQ-027 On WAIT_END exit: if o_valid=0, or o_valid=1 and i_ack=1 same cycle, load all output fields and set o_valid=1 next cycle; else o_ovf_cnt +1, outputs unchanged.
REQ-028 o_valid cleared the cycle after i_ack=1 unless a reload occurs that same cycle (REQ-027); i_ack with o_valid=0 ignored.
REQ-029 Output fields stable while o_valid=1.
REQ-030 Counters saturate at 8'hFF, no wrap.
REQ-031 Parser runs independently of o_valid; a held output never stalls reception.
REQ-032 Back-to-back frames with a single dv-low cycle between them are both parsed.

Reset
REQ-033 rst=1 at clk edge: state IDLE, byte counter 0, o_valid 0, all output fields 0, both counters 0.
REQ-034 rst mid-frame aborts parsing without counting; after release, remaining bytes of that frame (no SFD seen) go to DROP and count once.

Verification
REQ-035 Broadcast ARP request, TPA=i_local_ip=C0A80102, SHA=001122334455 -> o_valid=1 one cycle after dv falls, o_operation=1, o_SHA=001122334455, o_drop_cnt=0.
REQ-036 Same frame with TPA=C0A80103 -> o_valid stays 0, o_drop_cnt=1.
REQ-037 Ethertype 0x0800 frame, then dv drop after SPA in an ARP frame -> o_drop_cnt=2, o_valid 0.
REQ-038 Two valid frames, no i_ack -> first frame's fields held, o_ovf_cnt=1; i_ack on second frame's load cycle -> second frame loaded, o_ovf_cnt unchanged.
REQ-039 300 rejected frames -> o_drop_cnt=FF.
REQ-040 rst asserted during SHA of a valid frame -> o_valid 0, counters 0; next valid frame accepted normally.
